// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   src_e      - which requester owns a memory access (fetch or data)
//   arb_tag_t  - per-access tag carried alongside the memory latency
//   STARVE_W   - width of the fetch starvation counter
package mem_arb_pkg;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    typedef struct packed {
        logic vld;
        src_e src;
        logic we;
    } arb_tag_t;

    localparam int STARVE_W = 4;

    localparam arb_tag_t TAG_IDLE = '{vld: 1'b0, src: SRC_I, we: 1'b0};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the memory
// port of the arbiter.
//   slave  - the arbiter's view: requests and m_rdata in; ready, responses
//            and memory strobes out
//   master - the environment's view (CPU requesters plus memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    // fetch port
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_ready;
    logic                  i_flush;
    logic                  i_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_data;
    // data port
    logic                  d_req_valid;
    logic                  d_req_we;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_req_ready;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rsp_data;
    // memory port
    logic                  m_en;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport slave (
        input  i_req_valid, i_req_addr, i_flush,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  m_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req_valid, i_req_addr, i_flush,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output m_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// arb_tag_pipe: MEM_LAT-deep shift register of access tags that tracks each
// memory access until its read data appears on m_rdata.
//   clk, rst   - clock, synchronous active-high reset (empties the pipe)
//   flush      - kill every fetch tag in flight, including the one entering
//                and the one currently leaving
//   issue_tag  - tag of the access granted this cycle
//   rsp_tag    - tag whose data is on m_rdata this cycle
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  arb_tag_t issue_tag,
    output arb_tag_t rsp_tag
);

    arb_tag_t tag_p [MEM_LAT];

    function automatic arb_tag_t drop_fetch(input arb_tag_t t, input logic drop);
        arb_tag_t r;
        r = t;
        if (drop && t.src == SRC_I) begin
            r.vld = 1'b0;
        end
        return r;
    endfunction

    // stage 0 captures the grant; stage k takes stage k-1 every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                tag_p[k] <= TAG_IDLE;
            end
        end else begin
            tag_p[0] <= drop_fetch(issue_tag, flush);
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_p[k] <= drop_fetch(tag_p[k-1], flush);
            end
        end
    end

    // last stage lines up with m_rdata; a flush in this cycle also kills it
    assign rsp_tag = drop_fetch(tag_p[MEM_LAT-1], flush);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the
// instruction fetch port (read-only) and the data load/store port.
// Data wins arbitration unless fetch has waited STARVE_MAX consecutive cycles.
// Read data returns MEM_LAT cycles after the grant and is steered back to
// its requester by a tag pipe.
//   clk, rst - clock, synchronous active-high reset
//   bus      - mem_port_arbiter_if.slave: fetch port (i_*), data port (d_*),
//              memory port (m_*)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic                  grant_i;
    logic                  grant_d;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    arb_tag_t              issue_tag;
    arb_tag_t              rsp_tag;
    logic                  rsp_i_hit;
    logic                  rsp_d_hit;
    logic [DATA_WIDTH-1:0] d_rsp_fresh;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;

    function automatic logic [STARVE_W-1:0] starve_next(input logic [STARVE_W-1:0] cnt);
        if (cnt >= STARVE_LIM) begin
            return STARVE_LIM;
        end
        return cnt + 1'b1;
    endfunction

    // grant: data first, fetch once it has waited STARVE_MAX cycles
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.d_req_valid && bus.i_req_valid) begin
                if (starve_cnt < STARVE_LIM) begin
                    grant_d = 1'b1;
                end else begin
                    grant_i = 1'b1;
                end
            end else if (bus.d_req_valid) begin
                grant_d = 1'b1;
            end else if (bus.i_req_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        if (grant_d) begin
            addr_sel  = bus.d_req_addr;
            wdata_sel = bus.d_req_wdata;
        end else if (grant_i) begin
            addr_sel  = bus.i_req_addr;
        end
    end

    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;
    assign bus.m_en        = grant_i | grant_d;
    assign bus.m_we        = grant_d & bus.d_req_we;
    assign bus.m_addr      = addr_sel;
    assign bus.m_wdata     = wdata_sel;

    // a fetch that is not waiting has nothing to be starved of
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.i_req_valid || grant_i) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next(starve_cnt);
        end
    end

    always_comb begin
        issue_tag.vld = grant_i | grant_d;
        issue_tag.src = grant_d ? SRC_D : SRC_I;
        issue_tag.we  = grant_d & bus.d_req_we;
    end

    // grant -> response: MEM_LAT cycles of tag tracking
    arb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.i_flush),
        .issue_tag (issue_tag),
        .rsp_tag   (rsp_tag)
    );

    // rst gating keeps a tag leaving the pipe during reset from surfacing
    assign rsp_i_hit   = !rst && rsp_tag.vld && (rsp_tag.src == SRC_I);
    assign rsp_d_hit   = !rst && rsp_tag.vld && (rsp_tag.src == SRC_D);
    assign d_rsp_fresh = rsp_tag.we ? '0 : bus.m_rdata;

    // response data is live on the pulse and held from these registers after
    always_ff @(posedge clk) begin
        if (rst) begin
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (rsp_i_hit) begin
                i_data_q <= bus.m_rdata;
            end
            if (rsp_d_hit) begin
                d_data_q <= d_rsp_fresh;
            end
        end
    end

    assign bus.i_rsp_valid = rsp_i_hit;
    assign bus.i_rsp_data  = rsp_i_hit ? bus.m_rdata : i_data_q;
    assign bus.d_rsp_valid = rsp_d_hit;
    assign bus.d_rsp_data  = rsp_d_hit ? d_rsp_fresh : d_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (MEM_LAT = 1, 2, 3) driven by the same
// requester stimulus, each with its own read-latency line in front of a
// shared memory array.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int NL   = 3;
    localparam int SMAX = 4;
    localparam int NRND = 800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_load;
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_flush;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;

    logic          i_req_ready_o [NL];
    logic          d_req_ready_o [NL];
    logic          i_rsp_valid_o [NL];
    logic          d_rsp_valid_o [NL];
    logic [DW-1:0] i_rsp_data_o  [NL];
    logic [DW-1:0] d_rsp_data_o  [NL];
    logic          m_en_o        [NL];
    logic          m_we_o        [NL];
    logic [AW-1:0] m_addr_o      [NL];
    logic [DW-1:0] m_wdata_o     [NL];

    logic [DW-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        logic [DW-1:0] rd_pipe [g+1];

        assign bus.i_req_valid = i_req_valid;
        assign bus.i_req_addr  = i_req_addr;
        assign bus.i_flush     = i_flush;
        assign bus.d_req_valid = d_req_valid;
        assign bus.d_req_we    = d_req_we;
        assign bus.d_req_addr  = d_req_addr;
        assign bus.d_req_wdata = d_req_wdata;
        assign bus.m_rdata     = rd_pipe[g];

        always @(posedge clk) begin
            rd_pipe[0] <= mem[bus.m_addr[7:0]];
            for (int k = 1; k <= g; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end
        end

        assign i_req_ready_o[g] = bus.i_req_ready;
        assign d_req_ready_o[g] = bus.d_req_ready;
        assign i_rsp_valid_o[g] = bus.i_rsp_valid;
        assign d_rsp_valid_o[g] = bus.d_rsp_valid;
        assign i_rsp_data_o[g]  = bus.i_rsp_data;
        assign d_rsp_data_o[g]  = bus.d_rsp_data;
        assign m_en_o[g]        = bus.m_en;
        assign m_we_o[g]        = bus.m_we;
        assign m_addr_o[g]      = bus.m_addr;
        assign m_wdata_o[g]     = bus.m_wdata;

        mem_port_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LAT    (g + 1),
            .STARVE_MAX (SMAX)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int a = 0; a < 256; a++) begin
                mem[a] <= init_word(8'(a));
            end
        end else if (m_en_o[0] && m_we_o[0]) begin
            mem[m_addr_o[0][7:0]] <= m_wdata_o[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_flush     = 1'b0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = '0;
        d_req_wdata = '0;
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        rst = 1'b1;
        mem_load = 1'b1;
        set_idle();
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0001;
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 16'h0002;
        d_req_wdata = 16'h1234;
        repeat (2) tick();
        @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            obs = {i_req_ready_o[g], d_req_ready_o[g], m_en_o[g], m_we_o[g], m_addr_o[g],
                   m_wdata_o[g], i_rsp_valid_o[g], d_rsp_valid_o[g], i_rsp_data_o[g], d_rsp_data_o[g]};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs lat=%0d got %h want 0", g + 1, obs);
            end
        end
        tick();
        rst = 1'b0;
        mem_load = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic test_fetch();
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0010;
        @(negedge clk);
        checks++;
        if ({i_req_ready_o[0], m_en_o[0], m_addr_o[0], i_rsp_valid_o[0]} !== {1'b1, 1'b1, 16'h0010, 1'b0}) begin
            errors++;
            $display("FAIL fetch_grant0 got rdy=%b en=%b addr=%h rv=%b want 1 1 0010 0",
                     i_req_ready_o[0], m_en_o[0], m_addr_o[0], i_rsp_valid_o[0]);
        end
        tick();
        i_req_addr = 16'h0011;
        @(negedge clk);
        checks++;
        if ({i_req_ready_o[0], m_addr_o[0]} !== {1'b1, 16'h0011}) begin
            errors++;
            $display("FAIL fetch_grant1 got rdy=%b addr=%h want 1 0011", i_req_ready_o[0], m_addr_o[0]);
        end
        checks++;
        if ({i_rsp_valid_o[0], i_rsp_data_o[0]} !== {1'b1, init_word(8'h10)}) begin
            errors++;
            $display("FAIL fetch_rsp0 got v=%b d=%h want 1 %h", i_rsp_valid_o[0], i_rsp_data_o[0], init_word(8'h10));
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if ({i_rsp_valid_o[0], i_rsp_data_o[0]} !== {1'b1, init_word(8'h11)}) begin
            errors++;
            $display("FAIL fetch_rsp1 got v=%b d=%h want 1 %h", i_rsp_valid_o[0], i_rsp_data_o[0], init_word(8'h11));
        end
        checks++;
        if ({i_rsp_valid_o[1], i_rsp_data_o[1]} !== {1'b1, init_word(8'h10)}) begin
            errors++;
            $display("FAIL fetch_rsp_lat2 got v=%b d=%h want 1 %h", i_rsp_valid_o[1], i_rsp_data_o[1], init_word(8'h10));
        end
        tick();
        @(negedge clk);
        checks++;
        if ({i_rsp_valid_o[0], i_rsp_data_o[0]} !== {1'b0, init_word(8'h11)}) begin
            errors++;
            $display("FAIL fetch_hold got v=%b d=%h want 0 %h", i_rsp_valid_o[0], i_rsp_data_o[0], init_word(8'h11));
        end
        repeat (3) tick();
    endtask

    task automatic test_store_load();
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 16'h0020;
        d_req_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({d_req_ready_o[0], m_en_o[0], m_we_o[0], m_addr_o[0], m_wdata_o[0]} !== {3'b111, 16'h0020, 16'hBEEF}) begin
            errors++;
            $display("FAIL store_issue got rdy=%b en=%b we=%b addr=%h wd=%h want 1 1 1 0020 beef",
                     d_req_ready_o[0], m_en_o[0], m_we_o[0], m_addr_o[0], m_wdata_o[0]);
        end
        tick();
        d_req_we    = 1'b0;
        d_req_wdata = 16'h0000;
        @(negedge clk);
        checks++;
        if ({d_req_ready_o[0], m_we_o[0]} !== 2'b10) begin
            errors++;
            $display("FAIL load_issue got rdy=%b we=%b want 1 0", d_req_ready_o[0], m_we_o[0]);
        end
        checks++;
        if ({d_rsp_valid_o[0], d_rsp_data_o[0], i_rsp_valid_o[0]} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL store_ack got v=%b d=%h iv=%b want 1 0000 0", d_rsp_valid_o[0], d_rsp_data_o[0], i_rsp_valid_o[0]);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if ({d_rsp_valid_o[0], d_rsp_data_o[0], i_rsp_valid_o[0]} !== {1'b1, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL load_data got v=%b d=%h iv=%b want 1 beef 0", d_rsp_valid_o[0], d_rsp_data_o[0], i_rsp_valid_o[0]);
        end
        repeat (4) tick();
    endtask

    task automatic test_starve();
        logic want_i;
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0030;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 16'h0031;
        for (int k = 0; k < 10; k++) begin
            want_i = (k % 5 == 4);
            @(negedge clk);
            checks++;
            if ({i_req_ready_o[0], d_req_ready_o[0]} !== {want_i, !want_i}) begin
                errors++;
                $display("FAIL starve_pattern cycle=%0d got i=%b d=%b want i=%b d=%b",
                         k, i_req_ready_o[0], d_req_ready_o[0], want_i, !want_i);
            end
            checks++;
            if (g_dut[0].u_dut.starve_cnt > 4'(SMAX)) begin
                errors++;
                $display("FAIL starve_bound cycle=%0d got %0d want <= %0d", k, g_dut[0].u_dut.starve_cnt, SMAX);
            end
            tick();
        end
        set_idle();
        repeat (4) tick();
    endtask

    task automatic test_flush();
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0012;
        @(negedge clk);
        checks++;
        if (i_req_ready_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_fetch_grant got %b want 1", i_req_ready_o[0]);
        end
        tick();
        i_req_valid = 1'b0;
        i_flush     = 1'b1;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 16'h0013;
        @(negedge clk);
        checks++;
        if (d_req_ready_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL flush_load_grant got %b want 1", d_req_ready_o[2]);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (i_rsp_valid_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_lat2 got %b want 0", i_rsp_valid_o[1]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (i_rsp_valid_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_lat3 got %b want 0", i_rsp_valid_o[2]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({d_rsp_valid_o[2], d_rsp_data_o[2]} !== {1'b1, init_word(8'h13)}) begin
            errors++;
            $display("FAIL flush_keeps_d got v=%b d=%h want 1 %h", d_rsp_valid_o[2], d_rsp_data_o[2], init_word(8'h13));
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic [69:0] obs;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 16'h0014;
        @(negedge clk);
        checks++;
        if (d_req_ready_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant got %b want 1", d_req_ready_o[1]);
        end
        tick();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (d_rsp_valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_lat1 got %b want 0", d_rsp_valid_o[0]);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rsp_valid_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_lat2 got %b want 0", d_rsp_valid_o[1]);
        end
        for (int g = 0; g < NL; g++) begin
            obs = {i_req_ready_o[g], d_req_ready_o[g], m_en_o[g], m_we_o[g], m_addr_o[g],
                   m_wdata_o[g], i_rsp_valid_o[g], d_rsp_valid_o[g], i_rsp_data_o[g], d_rsp_data_o[g]};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL rstmid_outputs lat=%0d got %h want 0", g + 1, obs);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (d_rsp_valid_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_lat3 got %b want 0", d_rsp_valid_o[2]);
        end
        repeat (2) tick();
    endtask

    task automatic test_idle();
        i_req_valid = 1'b1;
        i_req_addr  = 16'h0015;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 16'h0016;
        repeat (2) tick();
        set_idle();
        @(negedge clk);
        checks++;
        if ({m_en_o[0], i_req_ready_o[0], d_req_ready_o[0]} !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_grant got en=%b ir=%b dr=%b want 0 0 0", m_en_o[0], i_req_ready_o[0], d_req_ready_o[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (g_dut[0].u_dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_starve got %0d want 0", g_dut[0].u_dut.starve_cnt);
        end
        repeat (4) tick();
    endtask

    task automatic test_random();
        int            mcnt;
        logic [15:0]   rmem  [16];
        logic          evi_v [NL][8];
        logic [15:0]   evi_d [NL][8];
        logic          evd_v [NL][8];
        logic [15:0]   evd_d [NL][8];
        logic [15:0]   last_i [NL];
        logic [15:0]   last_d [NL];
        logic          i_busy, d_busy, gi, gd, ev;
        logic [15:0]   ed;
        logic [3:0]    ia, da;
        int            slot;

        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        mcnt = 0;
        i_busy = 1'b0;
        d_busy = 1'b0;
        for (int k = 0; k < 16; k++) rmem[k] = init_word(8'(8'h40 + k));
        for (int g = 0; g < NL; g++) begin
            last_i[g] = '0;
            last_d[g] = '0;
            for (int s = 0; s < 8; s++) begin
                evi_v[g][s] = 1'b0;
                evd_v[g][s] = 1'b0;
                evi_d[g][s] = '0;
                evd_d[g][s] = '0;
            end
        end

        for (int c = 0; c < NRND; c++) begin
            if (!i_busy && c < NRND - 8 && $urandom_range(0, 3) != 0) begin
                i_busy = 1'b1;
                i_req_addr = 16'h0040 + 16'($urandom_range(0, 15));
            end
            i_req_valid = i_busy;
            if (!d_busy && c < NRND - 8 && $urandom_range(0, 9) < 6) begin
                d_busy = 1'b1;
                d_req_we = 1'($urandom_range(0, 1));
                d_req_addr = 16'h0040 + 16'($urandom_range(0, 15));
                d_req_wdata = 16'($urandom);
            end
            d_req_valid = d_busy;
            i_flush = (c < NRND - 8) && ($urandom_range(0, 15) == 0);
            ia = i_req_addr[3:0];
            da = d_req_addr[3:0];

            @(negedge clk);
            gi = 1'b0;
            gd = 1'b0;
            if (i_busy && d_busy) begin
                if (mcnt < SMAX) gd = 1'b1;
                else             gi = 1'b1;
            end else begin
                gi = i_busy;
                gd = d_busy;
            end

            if (i_flush) begin
                for (int g = 0; g < NL; g++) begin
                    for (int off = 0; off <= g + 1; off++) evi_v[g][(c + off) % 8] = 1'b0;
                end
            end

            slot = c % 8;
            for (int g = 0; g < NL; g++) begin
                checks++;
                if ({i_req_ready_o[g], d_req_ready_o[g], m_en_o[g], m_we_o[g]} !== {gi, gd, gi | gd, gd & d_req_we}) begin
                    errors++;
                    $display("FAIL rnd_grant lat=%0d cyc=%0d got ir=%b dr=%b en=%b we=%b want %b %b %b %b", g + 1, c,
                             i_req_ready_o[g], d_req_ready_o[g], m_en_o[g], m_we_o[g], gi, gd, gi | gd, gd & d_req_we);
                end
                if (gi || gd) begin
                    checks++;
                    if (m_addr_o[g] !== (gd ? d_req_addr : i_req_addr)) begin
                        errors++;
                        $display("FAIL rnd_addr lat=%0d cyc=%0d got %h want %h", g + 1, c, m_addr_o[g], gd ? d_req_addr : i_req_addr);
                    end
                end
                if (gd && d_req_we) begin
                    checks++;
                    if (m_wdata_o[g] !== d_req_wdata) begin
                        errors++;
                        $display("FAIL rnd_wdata lat=%0d cyc=%0d got %h want %h", g + 1, c, m_wdata_o[g], d_req_wdata);
                    end
                end

                ev = evi_v[g][slot];
                ed = ev ? evi_d[g][slot] : last_i[g];
                checks++;
                if ({i_rsp_valid_o[g], i_rsp_data_o[g]} !== {ev, ed}) begin
                    errors++;
                    $display("FAIL rnd_irsp lat=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", g + 1, c,
                             i_rsp_valid_o[g], i_rsp_data_o[g], ev, ed);
                end
                last_i[g] = ed;
                evi_v[g][slot] = 1'b0;

                ev = evd_v[g][slot];
                ed = ev ? evd_d[g][slot] : last_d[g];
                checks++;
                if ({d_rsp_valid_o[g], d_rsp_data_o[g]} !== {ev, ed}) begin
                    errors++;
                    $display("FAIL rnd_drsp lat=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", g + 1, c,
                             d_rsp_valid_o[g], d_rsp_data_o[g], ev, ed);
                end
                last_d[g] = ed;
                evd_v[g][slot] = 1'b0;

                if (gi && !i_flush) begin
                    evi_v[g][(c + g + 1) % 8] = 1'b1;
                    evi_d[g][(c + g + 1) % 8] = rmem[ia];
                end
                if (gd) begin
                    evd_v[g][(c + g + 1) % 8] = 1'b1;
                    evd_d[g][(c + g + 1) % 8] = d_req_we ? 16'h0000 : rmem[da];
                end
            end

            if (gd && d_req_we) rmem[da] = d_req_wdata;
            if (i_busy && !gi) mcnt = (mcnt + 1 > SMAX) ? SMAX : mcnt + 1;
            else               mcnt = 0;
            if (gi) i_busy = 1'b0;
            if (gd) d_busy = 1'b0;
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_starve();
        test_flush();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
